// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the write-back cache controller.
package cache_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WB     = 3'd2,
        S_REFILL = 3'd3,
        S_WAIT   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    // Field widths for the default geometry (32-bit address, 64 B lines, 128 sets, 4 ways).
    localparam int DEF_OFF_W = $clog2(64);
    localparam int DEF_IDX_W = $clog2(128);
    localparam int DEF_WAY_W = $clog2(4);
    localparam int DEF_TAG_W = 32 - DEF_OFF_W - DEF_IDX_W;

    function automatic int off_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int addr_w, input int line_bytes, input int num_sets);
        return addr_w - $clog2(line_bytes) - $clog2(num_sets);
    endfunction

    function automatic int byte_off_bits(input int word_w);
        return $clog2(word_w / 8);
    endfunction

    function automatic int way_bits(input int num_ways);
        return $clog2(num_ways);
    endfunction

endpackage

// File: rtl/cache_lru_set.sv
// True-LRU age tracker for one set: age 0 is most recent, NUM_WAYS-1 is the victim.
module cache_lru_set
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int WAY_W    = way_bits(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             touch,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAY_W-1:0] victim_way
);

    logic [WAY_W-1:0] age_q [NUM_WAYS];

    // Touched way becomes youngest; ways younger than it age by one, older ones keep their age.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WAYS; w++) age_q[w] <= WAY_W'(w);
        end else if (touch) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == touch_way)
                    age_q[w] <= '0;
                else if (age_q[w] < age_q[touch_way])
                    age_q[w] <= age_q[w] + 1'b1;
            end
        end
    end

    // Oldest way; ages always form a permutation so exactly one matches.
    always_comb begin
        victim_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (age_q[w] == WAY_W'(NUM_WAYS - 1)) victim_way = WAY_W'(w);
        end
    end

endmodule

// File: rtl/cache_wb_ctrl.sv
// Set-associative write-back / write-allocate cache with true-LRU and dirty eviction.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a CPU request
// S_LOOKUP | tag compare, hit update or victim selection
// S_WB     | writing dirty victim line back to memory
// S_REFILL | requesting the missing line from memory
// S_WAIT   | waiting for refill data, installs line on mem_rvalid
// S_RESP   | one-cycle completion pulse to the CPU
module cache_wb_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int NUM_SETS   = 128,
    parameter int NUM_WAYS   = 4,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [WORD_W-1:0]       req_wdata,
    input  logic [WORD_W/8-1:0]     req_wstrb,
    output logic                    resp_valid,
    output logic [WORD_W-1:0]       resp_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_write,
    output logic [ADDR_W-1:0]       mem_req_addr,
    output logic [LINE_BYTES*8-1:0] mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [LINE_BYTES*8-1:0] mem_rdata,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt,
    output logic [CNT_W-1:0]        evict_cnt
);

    localparam int OFF_W     = off_bits(LINE_BYTES);
    localparam int IDX_W     = idx_bits(NUM_SETS);
    localparam int TAG_W     = tag_bits(ADDR_W, LINE_BYTES, NUM_SETS);
    localparam int BOFF_W    = byte_off_bits(WORD_W);
    localparam int WAY_W     = way_bits(NUM_WAYS);
    localparam int LINE_W    = LINE_BYTES * 8;
    localparam int STRB_W    = WORD_W / 8;
    localparam int NUM_WORDS = LINE_W / WORD_W;
    localparam int WSEL_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              write_q;
    logic [WAY_W-1:0]  way_q;
    logic [WORD_W-1:0] rdata_q;

    logic [LINE_W-1:0]   data_mem [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q  [NUM_SETS];
    logic [WAY_W-1:0]    lru_victim [NUM_SETS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] wsel;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              inv_found;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  victim_way;
    logic              victim_dirty;

    logic [LINE_W-1:0] hit_line, wr_hit_line, fill_line;
    logic [WORD_W-1:0] hit_word, fill_word;

    logic              accept, lookup_hit, lookup_miss, wb_done, install;
    logic              lru_touch;
    logic [WAY_W-1:0]  touch_way;

    assign idx  = addr_q[OFF_W +: IDX_W];
    assign tag  = addr_q[OFF_W + IDX_W +: TAG_W];
    assign wsel = WSEL_W'(addr_q >> BOFF_W) & WSEL_W'(NUM_WORDS - 1);

    function automatic logic [WORD_W-1:0] merge_word(input logic [WORD_W-1:0] old_w,
                                                      input logic [WORD_W-1:0] new_w,
                                                      input logic [STRB_W-1:0] strb);
        logic [WORD_W-1:0] res;
        res = old_w;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return res;
    endfunction

    // Tag compare across the indexed set and victim choice (first invalid way, else LRU).
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[idx][w] && (tag_mem[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim_way   = inv_found ? inv_way : lru_victim[idx];
        victim_dirty = valid_q[idx][victim_way] && dirty_q[idx][victim_way];
    end

    // Word extraction and strobe merge for write hits and write-allocate refills.
    always_comb begin
        hit_line    = data_mem[idx][hit_way];
        hit_word    = hit_line[wsel*WORD_W +: WORD_W];
        fill_word   = mem_rdata[wsel*WORD_W +: WORD_W];
        wr_hit_line = hit_line;
        wr_hit_line[wsel*WORD_W +: WORD_W] = merge_word(hit_word, wdata_q, wstrb_q);
        fill_line   = mem_rdata;
        if (write_q) fill_line[wsel*WORD_W +: WORD_W] = merge_word(fill_word, wdata_q, wstrb_q);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, interface outputs and internal update strobes.
    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_wdata     = '0;
        accept        = 1'b0;
        lookup_hit    = 1'b0;
        lookup_miss   = 1'b0;
        wb_done       = 1'b0;
        install       = 1'b0;
        lru_touch     = 1'b0;
        touch_way     = '0;
        case (state_q)
            S_IDLE: begin
                // rst_n gating keeps ready low while reset is held.
                req_ready = rst_n;
                if (req_valid && rst_n) begin
                    accept  = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    lookup_hit = 1'b1;
                    lru_touch  = 1'b1;
                    touch_way  = hit_way;
                    state_d    = S_RESP;
                end else begin
                    lookup_miss = 1'b1;
                    state_d     = victim_dirty ? S_WB : S_REFILL;
                end
            end
            S_WB: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = ADDR_W'({tag_mem[idx][way_q], idx}) << OFF_W;
                mem_wdata     = data_mem[idx][way_q];
                if (mem_req_ready) begin
                    wb_done = 1'b1;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = ADDR_W'({tag, idx}) << OFF_W;
                if (mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    install   = 1'b1;
                    lru_touch = 1'b1;
                    touch_way = way_q;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, selected way and response word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            write_q <= 1'b0;
            way_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                write_q <= req_write;
            end
            if (lookup_hit) begin
                way_q   <= hit_way;
                rdata_q <= write_q ? '0 : hit_word;
            end
            if (lookup_miss) way_q <= victim_way;
            if (install) rdata_q <= write_q ? '0 : fill_word;
        end
    end

    // Valid and dirty bits; a write-allocated line is installed dirty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            if (lookup_hit && write_q) dirty_q[idx][hit_way] <= 1'b1;
            if (install) begin
                valid_q[idx][way_q] <= 1'b1;
                dirty_q[idx][way_q] <= write_q;
            end
        end
    end

    // Data and tag storage, not reset.
    always_ff @(posedge clk) begin
        if (lookup_hit && write_q) data_mem[idx][hit_way] <= wr_hit_line;
        if (install) begin
            data_mem[idx][way_q] <= fill_line;
            tag_mem[idx][way_q]  <= tag;
        end
    end

    // Saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            evict_cnt <= '0;
        end else begin
            if (lookup_hit  && (hit_cnt   != '1)) hit_cnt   <= hit_cnt + 1'b1;
            if (lookup_miss && (miss_cnt  != '1)) miss_cnt  <= miss_cnt + 1'b1;
            if (wb_done     && (evict_cnt != '1)) evict_cnt <= evict_cnt + 1'b1;
        end
    end

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_lru
        cache_lru_set #(.NUM_WAYS(NUM_WAYS)) u_lru (
            .clk        (clk),
            .rst_n      (rst_n),
            .touch      (lru_touch && (idx == IDX_W'(s))),
            .touch_way  (touch_way),
            .victim_way (lru_victim[s])
        );
    end

endmodule

// File: tb/tb_cache_wb_ctrl.sv
// Directed bench for cache_wb_ctrl with default geometry.
module tb_cache_wb_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic [3:0]   req_wstrb = '0;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic         mem_req_write;
    logic [31:0]  mem_req_addr;
    logic [511:0] mem_wdata;
    logic         mem_rvalid = 1'b0;
    logic [511:0] mem_rdata = '0;
    logic [31:0]  hit_cnt, miss_cnt, evict_cnt;

    int checks = 0;
    int failures = 0;

    cache_wb_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .evict_cnt(evict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] make_line(input logic [31:0] base);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; DUT is in LOOKUP afterwards.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        tick();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    endtask

    // From REFILL: accept the request, then return the line; DUT is in RESP afterwards.
    task automatic do_refill(input logic [511:0] line);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = line;
        tick();
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0h exp=0", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp got=%0h/%0h exp=0/0", resp_valid, resp_rdata); end
        checks++; if (mem_req_valid !== 1'b0 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h0 || mem_wdata !== 512'h0) begin failures++; $display("FAIL rst_mem got=%0h/%0h/%0h exp=0/0/0", mem_req_valid, mem_req_write, mem_req_addr); end
        checks++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0 || evict_cnt !== 32'h0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d/%0d exp=0/0/0", hit_cnt, miss_cnt, evict_cnt); end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%0h exp=1", req_ready); end
    endtask

    task automatic test_read_miss();
        issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        checks++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL miss_lookup got=%0h/%0h exp=0/0", mem_req_valid, req_ready); end
        tick();
        checks++; if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h0000_1000) begin failures++; $display("FAIL miss_refill_req got=%0h/%0h/%0h exp=1/0/1000", mem_req_valid, mem_req_write, mem_req_addr); end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checks++; if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL miss_wait got=%0h/%0h exp=0/0", mem_req_valid, resp_valid); end
        mem_rvalid = 1'b1; mem_rdata = make_line(32'h1000_0000);
        tick();
        mem_rvalid = 1'b0; mem_rdata = '0;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h1000_0000) begin failures++; $display("FAIL miss_resp got=%0h/%0h exp=1/10000000", resp_valid, resp_rdata); end
        checks++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin failures++; $display("FAIL miss_cnt got=%0d/%0d exp=1/0", miss_cnt, hit_cnt); end
        tick();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL miss_idle got=%0h/%0h exp=0/1", resp_valid, req_ready); end
    endtask

    task automatic test_read_hit();
        issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        checks++; if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL hit_lookup got=%0h/%0h exp=0/0", resp_valid, mem_req_valid); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h1000_0000 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL hit_resp got=%0h/%0h/%0h exp=1/10000000/0", resp_valid, resp_rdata, mem_req_valid); end
        checks++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin failures++; $display("FAIL hit_cnt got=%0d/%0d exp=1/1", hit_cnt, miss_cnt); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL hit_pulse got=%0h exp=0", resp_valid); end
    endtask

    task automatic test_write_strobe();
        issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b0011);
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin failures++; $display("FAIL wr_resp got=%0h/%0h exp=1/0", resp_valid, resp_rdata); end
        tick();
        issue(1'b0, 32'h0000_1004, 32'h0, 4'h0);
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h1000_BEEF) begin failures++; $display("FAIL wr_merge got=%0h/%0h exp=1/1000beef", resp_valid, resp_rdata); end
        checks++; if (hit_cnt !== 32'd3) begin failures++; $display("FAIL wr_hit_cnt got=%0d exp=3", hit_cnt); end
        tick();
    endtask

    task automatic test_dirty_evict();
        logic [511:0] exp_line;
        logic [31:0]  base;
        for (int k = 0; k < 4; k++) begin
            base = 32'hA000_0000 + 32'(k) * 32'h0001_0000;
            issue(k == 0, 32'(k) * 32'h2000, 32'hCAFE_F00D, 4'hF);
            tick();
            checks++; if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 32'(k) * 32'h2000) begin failures++; $display("FAIL fill_req%0d got=%0h/%0h/%0h exp=1/0/%0h", k, mem_req_valid, mem_req_write, mem_req_addr, k * 32'h2000); end
            do_refill(make_line(base));
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== ((k == 0) ? 32'h0 : base)) begin failures++; $display("FAIL fill_resp%0d got=%0h/%0h exp=1/%0h", k, resp_valid, resp_rdata, (k == 0) ? 32'h0 : base); end
            tick();
        end
        exp_line = make_line(32'hA000_0000);
        exp_line[31:0] = 32'hCAFE_F00D;
        issue(1'b0, 32'h0000_8000, 32'h0, 4'h0);
        tick();
        checks++; if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b1 || mem_req_addr !== 32'h0) begin failures++; $display("FAIL wb_req got=%0h/%0h/%0h exp=1/1/0", mem_req_valid, mem_req_write, mem_req_addr); end
        checks++; if (mem_wdata[63:0] !== {32'hA000_0001, 32'hCAFE_F00D}) begin failures++; $display("FAIL wb_data got=%0h exp=a0000001cafef00d", mem_wdata[63:0]); end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b1 || mem_req_addr !== 32'h0 || mem_wdata !== exp_line || req_ready !== 1'b0) begin failures++; $display("FAIL wb_hold%0d got=%0h/%0h/%0h/%0h exp=1/1/0/0", c, mem_req_valid, mem_req_write, mem_req_addr, req_ready); end
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h0000_8000) begin failures++; $display("FAIL wb_refill got=%0h/%0h/%0h exp=1/0/8000", mem_req_valid, mem_req_write, mem_req_addr); end
        checks++; if (evict_cnt !== 32'd1) begin failures++; $display("FAIL evict_cnt got=%0d exp=1", evict_cnt); end
        do_refill(make_line(32'hB000_0000));
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hB000_0000 || miss_cnt !== 32'd6) begin failures++; $display("FAIL wb_resp got=%0h/%0h/%0d exp=1/b0000000/6", resp_valid, resp_rdata, miss_cnt); end
        tick();
    endtask

    task automatic test_lru_order();
        issue(1'b0, 32'h0000_2000, 32'h0, 4'h0);
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hA001_0000 || hit_cnt !== 32'd4) begin failures++; $display("FAIL lru_hit got=%0h/%0h/%0d exp=1/a0010000/4", resp_valid, resp_rdata, hit_cnt); end
        tick();
        issue(1'b0, 32'h0000_A000, 32'h0, 4'h0);
        tick();
        checks++; if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h0000_A000) begin failures++; $display("FAIL lru_clean_victim got=%0h/%0h/%0h exp=1/0/a000", mem_req_valid, mem_req_write, mem_req_addr); end
        do_refill(make_line(32'hD000_0000));
        tick();
        issue(1'b0, 32'h0000_6000, 32'h0, 4'h0);
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hA003_0000 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL lru_keep got=%0h/%0h/%0h exp=1/a0030000/0", resp_valid, resp_rdata, mem_req_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 32'h0000_5040, 32'h0, 4'h0);
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin failures++; $display("FAIL midrst_cpu got=%0h/%0h/%0h exp=0/0/0", req_ready, resp_valid, resp_rdata); end
        checks++; if (mem_req_valid !== 1'b0 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h0 || mem_wdata !== 512'h0) begin failures++; $display("FAIL midrst_mem got=%0h/%0h/%0h exp=0/0/0", mem_req_valid, mem_req_write, mem_req_addr); end
        checks++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0 || evict_cnt !== 32'h0) begin failures++; $display("FAIL midrst_cnt got=%0d/%0d/%0d exp=0/0/0", hit_cnt, miss_cnt, evict_cnt); end
        mem_rvalid = 1'b1; mem_rdata = make_line(32'hEEEE_0000);
        tick();
        mem_rvalid = 1'b0; mem_rdata = '0;
        tick();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL midrst_noresp got=%0h exp=0", resp_valid); end
        rst_n = 1'b1;
        #1;
        issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        tick();
        checks++; if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h0000_1000) begin failures++; $display("FAIL midrst_miss got=%0h/%0h/%0h exp=1/0/1000", mem_req_valid, mem_req_write, mem_req_addr); end
        checks++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin failures++; $display("FAIL midrst_cnt2 got=%0d/%0d exp=1/0", miss_cnt, hit_cnt); end
        do_refill(make_line(32'hC000_0000));
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hC000_0000) begin failures++; $display("FAIL midrst_resp got=%0h/%0h exp=1/c0000000", resp_valid, resp_rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_strobe();
        test_dirty_evict();
        test_lru_order();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_wb_ctrl.md
Name: cache_wb_ctrl

Overview:
Parametrised set-associative write-back, write-allocate cache with integrated controller FSM and true-LRU replacement. CPU side is a word-wide valid/ready request channel with a response pulse. Memory side is a line-wide request/response handshake that performs real dirty-line writeback before refill. Successor of the fixed 4-way/128-set cache+fsm pair; adds dirty eviction, byte strobes, backpressure and statistics counters.

Parameters:
ADDR_W, 32, byte address width
WORD_W, 32, CPU data width (bits, power of 2, >=8)
LINE_BYTES, 64, line size in bytes (power of 2, >= WORD_W/8)
NUM_SETS, 128, sets (power of 2, >=2)
NUM_WAYS, 4, associativity (power of 2, 2..16)
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  high only in IDLE
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address; low log2(WORD_W/8) bits ignored
req_wdata  in  WORD_W  write word
req_wstrb  in  WORD_W/8  byte enables for writes
resp_valid  out  1  one-cycle completion pulse (reads and writes)
resp_rdata  out  WORD_W  read word, valid with resp_valid; 0 for writes
mem_req_valid  out  1  memory request valid, held until accepted
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1=writeback, 0=refill
mem_req_addr  out  ADDR_W  line-aligned address (offset bits 0)
mem_wdata  out  LINE_BYTES*8  victim line for writeback
mem_rvalid  in  1  refill data valid (one cycle)
mem_rdata  in  LINE_BYTES*8  refill line
hit_cnt, miss_cnt, evict_cnt  out  CNT_W each  saturating statistics

Behaviour:
- Address split: OFF=log2(LINE_BYTES), IDX=log2(NUM_SETS), TAG=ADDR_W-OFF-IDX; word select = addr[OFF-1:log2(WORD_W/8)].
- Reset (async, rst_n=0): state IDLE; all valid/dirty bits 0; per-set age of way w = w; req_ready=0 during reset, 1 in first IDLE cycle after; resp_valid=0, resp_rdata=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_wdata=0, counters=0. Data/tag arrays not reset. Reset mid-transaction abandons it; no response issued.
- Request latched on req_valid&&req_ready in IDLE; addr/wdata/wstrb/write captured; inputs ignored afterwards.
- FSM: IDLE -> LOOKUP (accept). LOOKUP: hit -> RESP; miss -> WB if victim valid&&dirty, else REFILL. WB: mem_req_valid=1, write=1, addr={victim tag,idx,0}, wdata=victim line; on mem_req_ready -> REFILL. REFILL: mem_req_valid=1, write=0, addr={tag,idx,0}; after mem_req_ready -> WAIT. WAIT: on mem_rvalid install line -> RESP. RESP: resp_valid=1 one cycle -> IDLE.
- Hit latency: resp_valid exactly 2 cycles after acceptance cycle (IDLE, LOOKUP, RESP).
- Victim: lowest-index invalid way; if none, way with age NUM_WAYS-1.
- Write hit: merge req_wdata into word under wstrb, set dirty. Write miss: install refill line with merged word, dirty=1. Read miss: dirty=0, rdata from refill line.
- LRU on every hit and install: touched way age->0; ways with age < old age increment; others unchanged. Ages in a set always a permutation of 0..NUM_WAYS-1.
- mem_rvalid outside WAIT ignored. mem_req_ready while mem_req_valid=0 ignored.
- Counters: hit_cnt +1 per LOOKUP hit, miss_cnt +1 per miss, evict_cnt +1 per completed writeback; saturate at all-ones, no wrap.
- No request reordering; one outstanding transaction.

Decomposition:
- Package cache_pkg: state enum (IDLE, LOOKUP, WB, REFILL, WAIT, RESP), address field width functions, clog2 constants.
- Sub-module cache_lru_set: per-set age array with touch(way) and victim(way) outputs, parametrised by NUM_WAYS; instantiated as array indexed by set.

Test Plan:
- Reset then read 0x0000_1000 -> miss, refill request addr 0x1000 write=0, respond mem_rdata word0, resp_valid 2 cycles after mem_rvalid cycle+1; miss_cnt=1.
- Repeat same read -> hit, resp_valid exactly 2 cycles after accept, hit_cnt=1, no mem_req_valid.
- Write 0xDEADBEEF wstrb=4'b0011 to resident 0x1004, then read 0x1004 -> rdata upper half unchanged, lower 0xBEEF.
- Fill set 0 with 5 distinct tags (default params, stride 0x2000), first written -> 5th miss writebacks LRU line addr 0x0000, mem_wdata contains merged data; evict_cnt=1.
- Hold mem_req_ready=0 for 10 cycles during WB -> mem_req_valid/addr/wdata stable, req_ready=0.
- Assert rst_n=0 during WAIT -> outputs at reset values immediately; after release, previously hit address misses.
